// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU sharing arbiter.
// Opcodes are listed for reference only; the arbiter forwards them untouched.
package alu_pkg;

    localparam logic [3:0] ALU_XOR  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_MOV  = 4'b1000;
    localparam logic [3:0] ALU_SHF  = 4'b1001;
    localparam logic [3:0] ALU_ADDI = 4'b1010;
    localparam logic [3:0] ALU_SUBI = 4'b1011;

    typedef struct packed {
        logic sco;
        logic jen;
        logic par;
        logic zero;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester channel: valid/ready request plus valid/ready response drain.
// The master side is the requester, the slave side is the arbiter.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int W = 8
)
();
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [2:0]   req_imm;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rslt;
    alu_flags_t   rsp_flags;

    modport master (
        output req_valid, req_op, req_imm, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_rslt, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_imm, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_rslt, rsp_flags
    );
endinterface

// File: rtl/rsp_buf1.sv
// One-deep response register; a load on the same edge as a drain wins,
// so the new result is never lost.
module rsp_buf1
    import alu_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_rslt,
    input  alu_flags_t   i_flags,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_rslt,
    output alu_flags_t   o_flags
);
    logic         r_valid;
    logic [W-1:0] r_rslt;
    alu_flags_t   r_flags;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rslt  <= '0;
            r_flags <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rslt  <= i_rslt;
            r_flags <= i_flags;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_rslt  = r_rslt;
    assign o_flags = r_flags;
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight, registered operands and per-port result buffers.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int W           = 8,
    parameter int PRIO0_FIRST = 1
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_share_arbiter_if.slave   p_port0,
    alu_share_arbiter_if.slave   p_port1,
    output logic [3:0]           o_alu_op,
    output logic [2:0]           o_alu_imm,
    output logic [W-1:0]         o_alu_dat_a,
    output logic [W-1:0]         o_alu_dat_b,
    input  logic [W-1:0]         i_alu_rslt,
    input  logic                 i_alu_zero,
    input  logic                 i_alu_par,
    input  logic                 i_alu_jen,
    input  logic                 i_alu_sco,
    output logic                 o_busy
);
    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic         r_last;
    logic         r_owner;
    logic         w_elig0;
    logic         w_elig1;
    logic         w_grant_vld;
    logic         w_grant;
    logic         w_cap0;
    logic         w_cap1;
    alu_flags_t   w_alu_flags;

    // A full buffer still counts as free when it is being drained this cycle.
    assign w_elig0 = p_port0.req_valid && (!p_port0.rsp_valid || p_port0.rsp_ready);
    assign w_elig1 = p_port1.req_valid && (!p_port1.rsp_valid || p_port1.rsp_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_vld = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 && w_elig1) begin
                    w_grant_vld = 1'b1;
                    w_grant     = ~r_last;
                end else if (w_elig0) begin
                    w_grant_vld = 1'b1;
                    w_grant     = 1'b0;
                end else if (w_elig1) begin
                    w_grant_vld = 1'b1;
                    w_grant     = 1'b1;
                end
                if (w_grant_vld) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign p_port0.req_ready = w_grant_vld && !w_grant;
    assign p_port1.req_ready = w_grant_vld &&  w_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_last      <= (PRIO0_FIRST != 0);
            r_owner     <= 1'b0;
            o_alu_op    <= '0;
            o_alu_imm   <= '0;
            o_alu_dat_a <= '0;
            o_alu_dat_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_vld) begin
                r_owner     <= w_grant;
                r_last      <= w_grant;
                o_alu_op    <= w_grant ? p_port1.req_op  : p_port0.req_op;
                o_alu_imm   <= w_grant ? p_port1.req_imm : p_port0.req_imm;
                o_alu_dat_a <= w_grant ? p_port1.req_a   : p_port0.req_a;
                o_alu_dat_b <= w_grant ? p_port1.req_b   : p_port0.req_b;
            end
        end
    end

    assign o_busy      = (r_state == EXEC);
    assign w_cap0      = (r_state == EXEC) && !r_owner;
    assign w_cap1      = (r_state == EXEC) &&  r_owner;
    assign w_alu_flags = {i_alu_sco, i_alu_jen, i_alu_par, i_alu_zero};

    rsp_buf1 #(.W(W)) u_rsp0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_cap0),
        .i_rslt  (i_alu_rslt),
        .i_flags (w_alu_flags),
        .i_ready (p_port0.rsp_ready),
        .o_valid (p_port0.rsp_valid),
        .o_rslt  (p_port0.rsp_rslt),
        .o_flags (p_port0.rsp_flags)
    );

    rsp_buf1 #(.W(W)) u_rsp1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_cap1),
        .i_rslt  (i_alu_rslt),
        .i_flags (w_alu_flags),
        .i_ready (p_port1.rsp_ready),
        .o_valid (p_port1.rsp_valid),
        .o_rslt  (p_port1.rsp_rslt),
        .o_flags (p_port1.rsp_flags)
    );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives the datapath, and a
// transaction-level model of grants and response buffers predicts every output.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.W(8)) if0 ();
    alu_share_arbiter_if #(.W(8)) if1 ();

    logic [3:0] alu_op;
    logic [2:0] alu_imm;
    logic [7:0] alu_a, alu_b, alu_rslt;
    logic       alu_zero, alu_par, alu_jen, alu_sco, busy;

    // Result layout: {sco, jen, par, zero, rslt[7:0]}; shift is rotate-left by imm.
    function automatic logic [11:0] alu_f(logic [3:0] op, logic [2:0] imm,
                                          logic [7:0] a, logic [7:0] b);
        logic [8:0]  t;
        logic [15:0] d;
        logic [7:0]  r;
        logic        c;
        t = '0; c = 1'b0; r = a;
        case (op)
            ALU_XOR:  r = a ^ b;
            ALU_ADD:  begin t = {1'b0, a} + {1'b0, b};       r = t[7:0]; c = t[8]; end
            ALU_SUB:  begin t = {1'b0, a} - {1'b0, b};       r = t[7:0]; c = t[8]; end
            ALU_ADDI: begin t = {1'b0, a} + {6'b0, imm};     r = t[7:0]; c = t[8]; end
            ALU_SUBI: begin t = {1'b0, a} - {6'b0, imm};     r = t[7:0]; c = t[8]; end
            ALU_MOV:  r = b;
            ALU_SHF:  begin d = {a, a} << imm; r = d[15:8]; end
            default:  r = a;
        endcase
        return {c, op[3] & imm[0], ^r, (r == 8'h00), r};
    endfunction

    assign {alu_sco, alu_jen, alu_par, alu_zero, alu_rslt} = alu_f(alu_op, alu_imm, alu_a, alu_b);

    alu_share_arbiter #(.W(8), .PRIO0_FIRST(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .p_port0     (if0),
        .p_port1     (if1),
        .o_alu_op    (alu_op),
        .o_alu_imm   (alu_imm),
        .o_alu_dat_a (alu_a),
        .o_alu_dat_b (alu_b),
        .i_alu_rslt  (alu_rslt),
        .i_alu_zero  (alu_zero),
        .i_alu_par   (alu_par),
        .i_alu_jen   (alu_jen),
        .i_alu_sco   (alu_sco),
        .o_busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state
    logic       m_busy, m_owner, m_last;
    logic       m_full [2];
    logic [7:0] m_rslt [2];
    logic [3:0] m_flg  [2];
    logic [3:0] m_op;
    logic [2:0] m_imm;
    logic [7:0] m_a, m_b;

    // Drive values
    logic       d_v  [2];
    logic       d_rr [2];
    logic [3:0] d_op [2];
    logic [2:0] d_imm[2];
    logic [7:0] d_a  [2];
    logic [7:0] d_b  [2];

    int gq[$];

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1;
        m_op = '0; m_imm = '0; m_a = '0; m_b = '0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_rslt[i] = '0; m_flg[i] = '0;
        end
    endtask

    task automatic set_port(int p, logic v, logic rr, logic [3:0] op, logic [2:0] imm,
                            logic [7:0] a, logic [7:0] b);
        d_v[p] = v; d_rr[p] = rr; d_op[p] = op; d_imm[p] = imm; d_a[p] = a; d_b[p] = b;
    endtask

    // Called at a negedge; drives, checks, advances the model, returns at next negedge.
    task automatic cycle();
        int          g;
        logic        e0, e1;
        logic [11:0] res;
        if0.req_valid = d_v[0]; if0.req_op = d_op[0]; if0.req_imm = d_imm[0];
        if0.req_a = d_a[0]; if0.req_b = d_b[0]; if0.rsp_ready = d_rr[0];
        if1.req_valid = d_v[1]; if1.req_op = d_op[1]; if1.req_imm = d_imm[1];
        if1.req_a = d_a[1]; if1.req_b = d_b[1]; if1.rsp_ready = d_rr[1];
        #1;
        e0 = d_v[0] && (!m_full[0] || d_rr[0]);
        e1 = d_v[1] && (!m_full[1] || d_rr[1]);
        g = -1;
        if (!m_busy) begin
            if (e0 && e1) g = m_last ? 0 : 1;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
        end
        chk("req0_ready", 32'(if0.req_ready), 32'(g == 0));
        chk("req1_ready", 32'(if1.req_ready), 32'(g == 1));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("alu_bus", {9'b0, alu_op, alu_imm, alu_a, alu_b}, {9'b0, m_op, m_imm, m_a, m_b});
        chk("rsp0_valid", 32'(if0.rsp_valid), 32'(m_full[0]));
        chk("rsp1_valid", 32'(if1.rsp_valid), 32'(m_full[1]));
        if (m_full[0]) chk("rsp0_data", {20'b0, if0.rsp_flags, if0.rsp_rslt}, {20'b0, m_flg[0], m_rslt[0]});
        if (m_full[1]) chk("rsp1_data", {20'b0, if1.rsp_flags, if1.rsp_rslt}, {20'b0, m_flg[1], m_rslt[1]});
        if (if0.req_ready && d_v[0]) gq.push_back(0);
        if (if1.req_ready && d_v[1]) gq.push_back(1);
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (m_full[i] && d_rr[i]) m_full[i] = 0;
        if (m_busy) begin
            res = alu_f(m_op, m_imm, m_a, m_b);
            m_full[m_owner] = 1;
            m_rslt[m_owner] = res[7:0];
            m_flg[m_owner]  = res[11:8];
            m_busy = 0;
        end else if (g >= 0) begin
            m_busy = 1; m_owner = g[0]; m_last = g[0];
            m_op = d_op[g]; m_imm = d_imm[g]; m_a = d_a[g]; m_b = d_b[g];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Port 0 alone: handshake, exec, then response is visible.
    task automatic single0(logic [3:0] op, logic [2:0] imm, logic [7:0] a, logic [7:0] b);
        set_port(0, 1, 1, op, imm, a, b);
        set_port(1, 0, 1, '0, '0, '0, '0);
        cycle();
        d_v[0] = 0;
        cycle();
    endtask

    logic [7:0] snap;
    logic [3:0] ops [7];
    int         n0, n1, bound;

    initial begin
        ops = '{ALU_XOR, ALU_ADD, ALU_SUB, ALU_MOV, ALU_SHF, ALU_ADDI, ALU_SUBI};
        for (int i = 0; i < 2; i++) set_port(i, 0, 0, '0, '0, '0, '0);
        if0.req_valid = 0; if1.req_valid = 0; if0.rsp_ready = 0; if1.rsp_ready = 0;
        if0.req_op = '0; if0.req_imm = '0; if0.req_a = '0; if0.req_b = '0;
        if1.req_op = '0; if1.req_imm = '0; if1.req_a = '0; if1.req_b = '0;
        model_reset();
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp0_valid", 32'(if0.rsp_valid), 0);
        chk("reset_alu_bus", {9'b0, alu_op, alu_imm, alu_a, alu_b}, 0);
        do_reset();

        // ADD 7F+01 on port 0
        single0(ALU_ADD, 3'd0, 8'h7F, 8'h01);
        chk("add_rslt", 32'(if0.rsp_rslt), 32'h80);
        chk("add_flags", 32'(if0.rsp_flags), 32'b0010);
        chk("add_no_rsp1", 32'(if1.rsp_valid), 0);
        cycle();

        // Rotate-style shift
        single0(ALU_SHF, 3'b111, 8'h80, 8'h00);
        chk("shf_rslt", 32'(if0.rsp_rslt), 32'h40);
        cycle();

        // SUB to zero
        single0(ALU_SUB, 3'd0, 8'h33, 8'h33);
        chk("subz_rslt", 32'(if0.rsp_rslt), 32'h00);
        chk("subz_zero", 32'(if0.rsp_flags.zero), 1);
        chk("subz_par", 32'(if0.rsp_flags.par), 0);
        cycle();

        // Both ports continuously valid: strict alternation starting with port 0
        do_reset();
        gq.delete();
        set_port(0, 1, 1, ALU_XOR, 3'd0, 8'hAA, 8'h55);
        set_port(1, 1, 1, ALU_SUB, 3'd0, 8'h05, 8'h07);
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (if0.rsp_valid) begin
                chk("xor_rslt", 32'(if0.rsp_rslt), 32'hFF);
                chk("xor_par", 32'(if0.rsp_flags.par), 0);
            end
            if (if1.rsp_valid) begin
                chk("sub_rslt", 32'(if1.rsp_rslt), 32'hFE);
                chk("sub_sco", 32'(if1.rsp_flags.sco), 1);
            end
        end
        chk("alt_count", 32'(gq.size()), 4);
        for (int k = 0; k < gq.size(); k++) chk("alt_order", 32'(gq[k]), 32'(k % 2));

        // Port 1 holds its response: it must be skipped, port 0 gets every other cycle
        d_rr[1] = 0;
        bound = 0;
        while (!if1.rsp_valid && bound < 10) begin
            cycle();
            bound++;
        end
        chk("p1_rsp_arrived", 32'(if1.rsp_valid), 1);
        snap = if1.rsp_rslt;
        gq.delete();
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("p1_rslt_stable", 32'(if1.rsp_rslt), 32'(snap));
        end
        n0 = 0; n1 = 0;
        foreach (gq[k]) if (gq[k] == 0) n0++; else n1++;
        chk("p0_grants", 32'(n0), 5);
        chk("p1_grants", 32'(n1), 0);
        d_rr[1] = 1;
        cycle();
        cycle();

        // Async reset while an operation is in EXEC
        do_reset();
        set_port(0, 1, 1, ALU_ADD, 3'd0, 8'h12, 8'h34);
        set_port(1, 0, 1, '0, '0, '0, '0);
        cycle();
        d_v[0] = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp0_valid", 32'(if0.rsp_valid), 0);
        chk("rst_rsp1_valid", 32'(if1.rsp_valid), 0);
        chk("rst_alu_bus", {9'b0, alu_op, alu_imm, alu_a, alu_b}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_no_rsp", 32'(if0.rsp_valid), 0);
        gq.delete();
        set_port(0, 1, 1, ALU_MOV, 3'd0, 8'h00, 8'h5A);
        set_port(1, 1, 1, ALU_MOV, 3'd0, 8'h00, 8'hA5);
        cycle();
        chk("tie_count", 32'(gq.size()), 1);
        if (gq.size() > 0) chk("tie_port0", 32'(gq[0]), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                set_port(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters: port 0 is the core execute stage, port 1 is an auxiliary engine such as a bit-count/LUT helper.
- Per port: valid/ready request channel and a one-deep response buffer with valid/ready drain.
- Round-robin grant, registered ALU operands, registered result capture; one operation in flight.

Parameters:
- W, 8, data width of operands and result; must match ALU datapath.
- PRIO0_FIRST, 1, after reset, port 0 wins the first tie.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req0Valid  in  1  port 0 request valid.
- Req0Ready  out  1  port 0 request accepted this cycle when Valid&Ready.
- Req0Op  in  4  ALU opcode.
- Req0Imm  in  3  ALU immediate.
- Req0A  in  W  operand A.
- Req0B  in  W  operand B.
- Req1Valid, Req1Ready, Req1Op, Req1Imm, Req1A, Req1B: same as port 0, for port 1.
- Rsp0Valid  out  1  port 0 response buffer full.
- Rsp0Ready  in  1  port 0 consumes response when Valid&Ready.
- Rsp0Rslt  out  W  captured ALU result.
- Rsp0Flags  out  4  {SCo,Jen,Par,Zero}.
- Rsp1Valid, Rsp1Ready, Rsp1Rslt, Rsp1Flags: same as port 0, for port 1.
- AluOp  out  4  to ALU Aluop.
- AluImm  out  3  to ALU Imm.
- AluDatA  out  W  to ALU DatA.
- AluDatB  out  W  to ALU DatB.
- AluRslt  in  W  from ALU Rslt.
- AluZero, AluPar, AluJen, AluSCo  in  1 each  ALU flags.
- Busy  out  1  high in EXEC.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all Alu* outputs, Rsp*Rslt and Rsp*Flags = 0.
  - Rsp*Valid=0, Req*Ready=0, Busy=0.
  - Last-grant pointer = 1 when PRIO0_FIRST=1, so port 0 wins the first tie.
- Eligibility: port i is eligible when ReqiValid=1 and its response buffer is empty, or is being drained this cycle (RspiValid&RspiReady).
- Req*Ready is combinational and asserted only in IDLE, only for the granted eligible port; at most one Ready is high per cycle.
- IDLE:
  - One eligible port: grant it.
  - Both eligible: grant the port other than the last-grant pointer.
  - On handshake, register Op/Imm/A/B onto Alu* outputs, record the owner, update the last-grant pointer, go to EXEC.
  - No eligible port: stay in IDLE; Alu* outputs hold their previous values.
- EXEC (exactly one cycle):
  - ALU evaluates the registered operands combinationally.
  - At the rising edge, AluRslt and {AluSCo,AluJen,AluPar,AluZero} load into the owner's response buffer and RspiValid is set; return to IDLE.
- Latency and throughput:
  - Request handshake at edge N; response visible after edge N+1; earliest next grant at edge N+2.
  - Peak throughput is 1 op per 2 cycles.
- Response buffer: RspiValid clears on the edge where RspiValid&RspiReady, unless an EXEC capture for the same port lands on the same edge. Eligibility blocks that case in practice; if both occur, the capture wins and Valid stays 1.
- Rsp*Rslt and Rsp*Flags hold stable while Valid=1 and Ready=0; they are not modified until the next capture.
- Fairness: with both ports continuously eligible, grants strictly alternate 0,1,0,1...
- Ineligible port: a port with a full, undrained buffer is skipped without consuming its turn; the pointer updates only on an actual grant.
- No width conversion: the block passes ALU values bit-exact and does not interpret opcodes; Jen is forwarded as a flag only.
- Reset mid-EXEC: the in-flight op is discarded, no response is produced, and the requester must reissue.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants: ALU_XOR=4'b0000, ALU_ADD=4'b0001, ALU_SUB=4'b0010, ALU_MOV=4'b1000, ALU_SHF=4'b1001, ALU_ADDI=4'b1010, ALU_SUBI=4'b1011.
  - Struct alu_flags_t {sco,jen,par,zero}.
  - enum arb_state_t {IDLE,EXEC}.
- One sub-module rsp_buf1 (one-deep response register with valid/ready, load, drain), instantiated twice.
- The grant logic stays inline.

Test Plan:
- Port 0 only, ADD A=8'h7F B=8'h01, Rsp0Ready=1:
  - Req0Ready high same cycle.
  - Rsp0Valid two edges later with Rslt=8'h80, Flags={0,0,1,0}.
  - Port 1 sees no response.
- Both ports continuously valid, port 0 XOR 8'hAA^8'h55, port 1 SUB 8'h05-8'h07, both Ready=1:
  - Grants alternate 0,1,0,1.
  - Port 0 Rslt=8'hFF, Par=0.
  - Port 1 Rslt=8'hFE, SCo=1.
- Rsp1Ready held 0 after first port 1 response, both requesting:
  - Port 1 not granted again.
  - Port 0 granted every 2 cycles.
  - Rsp1Rslt stable until Rsp1Ready=1.
- Port 0 shift op 4'b1001, Imm=3'b111, A=8'h80: Rsp0Rslt=8'h40 (right shift by 1).
- Port 0 SUB 8'h33-8'h33: Zero=1, Par=0, Rslt=8'h00.
- Reset asserted asynchronously mid-EXEC:
  - All Rsp*Valid=0 and Busy=0 immediately.
  - No response produced after deassertion.
  - First tie after reset granted to port 0.
